// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use and EX-use
// interlocks, multi-cycle MUL hold sequencing, jump squash, ID-stage bypass
// selection and a saturating stall counter.
//
// state | meaning
// IDLE  | normal issue; holds come only from data dependencies
// MUL   | MUL occupying EX; front end and EX frozen, EX/MEM fed bubbles
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_is_mul,
  input  logic        id_jump,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_write,
  input  logic [4:0]  mem_waddr,
  input  logic        mem_write,
  input  logic        mem_is_lw,
  input  logic [4:0]  wb_waddr,
  input  logic        wb_write,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic        exmem_bubble,
  output logic        mul_busy,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);
  localparam bit         MUL_SEQ  = (MUL_LAT > 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic dep_stall;

  // Per-stage source matches; register 0 never matches.
  always_comb begin
    ex_rs  = ex_write  && (ex_waddr  != 5'd0) && id_use_rs && (ex_waddr  == id_rs);
    ex_rt  = ex_write  && (ex_waddr  != 5'd0) && id_use_rt && (ex_waddr  == id_rt);
    mem_rs = mem_write && (mem_waddr != 5'd0) && id_use_rs && (mem_waddr == id_rs);
    mem_rt = mem_write && (mem_waddr != 5'd0) && id_use_rt && (mem_waddr == id_rt);
    wb_rs  = wb_write  && (wb_waddr  != 5'd0) && id_use_rs && (wb_waddr  == id_rs);
    wb_rt  = wb_write  && (wb_waddr  != 5'd0) && id_use_rt && (wb_waddr  == id_rt);
    dep_stall = ex_rs || ex_rt || ((mem_rs || mem_rt) && mem_is_lw);
  end

  // ID bypass select: MEM ALU result beats WB; a load in MEM is not bypassable.
  always_comb begin
    fwd_rs_sel = 2'b00;
    fwd_rt_sel = 2'b00;
    if (mem_rs && !mem_is_lw) fwd_rs_sel = 2'b01;
    else if (wb_rs)           fwd_rs_sel = 2'b10;
    if (mem_rt && !mem_is_lw) fwd_rt_sel = 2'b01;
    else if (wb_rt)           fwd_rt_sel = 2'b10;
  end

  // Next state, MUL down-counter and hazard outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_busy     = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    pc_hold      = dep_stall;
    ifid_hold    = dep_stall;
    idex_bubble  = dep_stall;
    ifid_flush   = id_jump && !dep_stall;
    case (state_q)
      IDLE: begin
        if (MUL_SEQ && id_is_mul && !dep_stall) begin
          state_d = MUL;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL: begin
        mul_busy     = 1'b1;
        ex_hold      = 1'b1;
        exmem_bubble = 1'b1;
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        cnt_d        = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter saturates rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State, counter and stall count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_waddr, mem_waddr, wb_waddr;
  logic        id_use_rs, id_use_rt, id_is_mul, id_jump;
  logic        ex_write, mem_write, mem_is_lw, wb_write;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, exmem_bubble, mul_busy;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;
  logic        pc_hold1, ifid_hold1, ifid_flush1, idex_bubble1, ex_hold1, exmem_bubble1, mul_busy1;
  logic [1:0]  fwd_rs_sel1, fwd_rt_sel1;
  logic [31:0] stall_cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_mul(id_is_mul), .id_jump(id_jump),
    .ex_waddr(ex_waddr), .ex_write(ex_write), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_is_lw(mem_is_lw), .wb_waddr(wb_waddr), .wb_write(wb_write),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ex_hold(ex_hold), .exmem_bubble(exmem_bubble), .mul_busy(mul_busy),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MUL_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_mul(id_is_mul), .id_jump(id_jump),
    .ex_waddr(ex_waddr), .ex_write(ex_write), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_is_lw(mem_is_lw), .wb_waddr(wb_waddr), .wb_write(wb_write),
    .pc_hold(pc_hold1), .ifid_hold(ifid_hold1), .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1),
    .ex_hold(ex_hold1), .exmem_bubble(exmem_bubble1), .mul_busy(mul_busy1),
    .fwd_rs_sel(fwd_rs_sel1), .fwd_rt_sel(fwd_rt_sel1), .stall_cnt(stall_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic clr_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_mul = 0; id_jump = 0;
    ex_waddr = 0; ex_write = 0; mem_waddr = 0; mem_write = 0; mem_is_lw = 0;
    wb_waddr = 0; wb_write = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    #3;
    chk("rst_mul_busy", 32'(mul_busy), 0);
    chk("rst_ex_hold", 32'(ex_hold), 0);
    chk("rst_exmem_bubble", 32'(exmem_bubble), 0);
    chk("rst_pc_hold", 32'(pc_hold), 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    settle();
    rst_n = 1'b1;
    tick();

    // LW $1 in EX, ID reads $1: two stall cycles, then WB bypass.
    ex_waddr = 1; ex_write = 1; id_rs = 1; id_use_rs = 1;
    settle();
    chk("lw_c1_pc_hold", 32'(pc_hold), 1);
    chk("lw_c1_idex_bubble", 32'(idex_bubble), 1);
    chk("lw_c1_ifid_hold", 32'(ifid_hold), 1);
    tick();
    ex_write = 0; ex_waddr = 0; mem_waddr = 1; mem_write = 1; mem_is_lw = 1;
    settle();
    chk("lw_c2_pc_hold", 32'(pc_hold), 1);
    chk("lw_c2_fwd_rs", 32'(fwd_rs_sel), 0);
    tick();
    mem_write = 0; mem_waddr = 0; mem_is_lw = 0; wb_waddr = 1; wb_write = 1;
    settle();
    chk("lw_c3_pc_hold", 32'(pc_hold), 0);
    chk("lw_c3_fwd_rs", 32'(fwd_rs_sel), 2);
    chk("lw_c3_stall_cnt", stall_cnt, 2);
    tick();

    // ADD $2 in MEM and WB: MEM wins, no stall.
    clr_in();
    mem_waddr = 2; mem_write = 1; wb_waddr = 2; wb_write = 1;
    id_rs = 2; id_use_rs = 1; id_rt = 2; id_use_rt = 1; id_jump = 1;
    settle();
    chk("mem_pri_pc_hold", 32'(pc_hold), 0);
    chk("mem_pri_fwd_rs", 32'(fwd_rs_sel), 1);
    chk("mem_pri_fwd_rt", 32'(fwd_rt_sel), 1);
    tick();

    // Register 0 never forwards or stalls.
    clr_in();
    ex_waddr = 0; ex_write = 1; mem_waddr = 0; mem_write = 1; mem_is_lw = 1;
    wb_waddr = 0; wb_write = 1; id_use_rs = 1; id_use_rt = 1;
    settle();
    chk("r0_pc_hold", 32'(pc_hold), 0);
    chk("r0_fwd", {30'd0, fwd_rs_sel} | {28'd0, fwd_rt_sel, 2'd0}, 0);
    tick();

    // rt-only WB match, rs unused.
    clr_in();
    wb_waddr = 9; wb_write = 1; id_rt = 9; id_use_rt = 1; id_rs = 9;
    settle();
    chk("wb_rt_fwd_rt", 32'(fwd_rt_sel), 2);
    chk("wb_rt_fwd_rs", 32'(fwd_rs_sel), 0);
    tick();

    // Taken jump, no dependency: one flush cycle.
    clr_in();
    id_jump = 1;
    settle();
    chk("j_flush", 32'(ifid_flush), 1);
    chk("j_pc_hold", 32'(pc_hold), 0);
    tick();
    id_jump = 0;
    settle();
    chk("j_flush_after", 32'(ifid_flush), 0);
    tick();

    // BNE on EX ADD: stall suppresses flush, then flush with MEM bypass.
    clr_in();
    id_jump = 1; id_rs = 3; id_use_rs = 1; ex_waddr = 3; ex_write = 1;
    settle();
    chk("bne_c1_flush", 32'(ifid_flush), 0);
    chk("bne_c1_pc_hold", 32'(pc_hold), 1);
    tick();
    ex_write = 0; ex_waddr = 0; mem_waddr = 3; mem_write = 1;
    settle();
    chk("bne_c2_flush", 32'(ifid_flush), 1);
    chk("bne_c2_fwd_rs", 32'(fwd_rs_sel), 1);
    chk("bne_c2_stall_cnt", stall_cnt, 3);
    tick();

    // MUL $5, then dependent ADD reading $5.
    clr_in();
    id_is_mul = 1;
    settle();
    chk("mul_pre_busy", 32'(mul_busy), 0);
    tick();
    id_is_mul = 0; ex_waddr = 5; ex_write = 1; id_rs = 5; id_use_rs = 1; id_jump = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mul_c%0d_busy", i), 32'(mul_busy), 1);
      chk($sformatf("mul_c%0d_ex_hold", i), 32'(ex_hold), 1);
      chk($sformatf("mul_c%0d_exmem_bubble", i), 32'(exmem_bubble), 1);
      chk($sformatf("mul_c%0d_pc_hold", i), 32'(pc_hold), 1);
      chk($sformatf("mul_c%0d_idex_bubble", i), 32'(idex_bubble), 0);
      chk($sformatf("mul_c%0d_flush", i), 32'(ifid_flush), 0);
      chk($sformatf("mul1_c%0d_busy", i), 32'(mul_busy1), 0);
      tick();
    end
    id_jump = 0;
    settle();
    chk("mul_rel_busy", 32'(mul_busy), 0);
    chk("mul_rel_ex_hold", 32'(ex_hold), 0);
    chk("mul_rel_dep_stall", 32'(pc_hold), 1);
    chk("mul_rel_idex_bubble", 32'(idex_bubble), 1);
    tick();
    ex_write = 0; ex_waddr = 0; mem_waddr = 5; mem_write = 1;
    settle();
    chk("mul_fwd_pc_hold", 32'(pc_hold), 0);
    chk("mul_fwd_rs", 32'(fwd_rs_sel), 1);
    chk("mul_stall_cnt", stall_cnt, 7);
    tick();

    // Reset during the second MUL cycle aborts immediately.
    clr_in();
    id_is_mul = 1;
    tick();
    id_is_mul = 0;
    tick();
    settle();
    chk("abort_pre_busy", 32'(mul_busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(mul_busy), 0);
    chk("abort_ex_hold", 32'(ex_hold), 0);
    chk("abort_pc_hold", 32'(pc_hold), 0);
    chk("abort_stall_cnt", stall_cnt, 0);
    #1 rst_n = 1'b1;
    tick();
    id_is_mul = 1;
    tick();
    id_is_mul = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("remul_c%0d_busy", i), 32'(mul_busy), 1);
      tick();
    end
    settle();
    chk("remul_rel_busy", 32'(mul_busy), 0);
    chk("remul_stall_cnt", stall_cnt, 3);
    tick();

    // Saturation of the stall counter.
    clr_in();
    ex_waddr = 7; ex_write = 1; id_rt = 7; id_use_rt = 1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    tick();
    settle();
    chk("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    tick();
    settle();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    tick();
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
